bcd_scan_display: RTL and testbench



---
 rtl/bcd_pkg.sv | 36 +++
 rtl/scan_prescaler.sv | 45 ++++
 rtl/bcd_scan_display.sv | 114 +++++++++++
 tb/tb_bcd_scan_display.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD / 7-segment definitions for the scan display.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  // Non-BCD codes render as a dash rather than an arbitrary glyph.
  function automatic logic [6:0] seg_decode(input bcd_digit_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler and digit-index counter; tick ends each slot, frame_boundary ends the last slot.
// Purely combinational outputs from the two counters; no backpressure.
module scan_prescaler #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int PW       = 10,
  parameter int IW       = 2
) (
  input  logic          ck_i,
  input  logic          nclear_i,
  output logic          tick_o,
  output logic          slot_start_o,
  output logic          frame_boundary_o,
  output logic [IW-1:0] idx_o
);

  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_idx;

  always_comb begin
    tick_o   = (presc_q == PW'(PRESCALE - 1));
    last_idx = (idx_q == IW'(DIGITS - 1));
    presc_d  = tick_o ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    if (tick_o) begin
      idx_d = last_idx ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge ck_i or negedge nclear_i) begin
    if (!nclear_i) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  assign slot_start_o     = (presc_q == '0);
  assign frame_boundary_o = tick_o && last_idx;
  assign idx_o            = idx_q;

endmodule

// File: rtl/bcd_scan_display.sv
// Double-buffered multiplexed 7-segment driver: 1-cycle output latency, new values land only at frame boundaries.
// No backpressure; BCD_SCAN_LZ_BLANK_EN enables leading-zero blanking.
module bcd_scan_display
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int PW       = 10
) (
  input  logic                  CK,
  input  logic                  nClear,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  upd,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done,
  output logic                  bad_digit
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic          unused_tick;
  logic          slot_start;
  logic          frame_boundary;
  logic [IW-1:0] idx;

  logic [4*DIGITS-1:0] staging_q, staging_d, disp_q, disp_d;
  logic                pending_q, pending_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                frame_done_q, bad_digit_q, bad_digit_d;
  bcd_digit_t          cur_digit;
`ifdef BCD_SCAN_LZ_BLANK_EN
  logic                upper_zero;
`endif

  scan_prescaler #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .PW       (PW),
    .IW       (IW)
  ) u_prescaler (
    .ck_i             (CK),
    .nclear_i         (nClear),
    .tick_o           (unused_tick),
    .slot_start_o     (slot_start),
    .frame_boundary_o (frame_boundary),
    .idx_o            (idx)
  );

  // An update coinciding with the boundary bypasses staging so it is not deferred a whole frame.
  always_comb begin
    staging_d = staging_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (upd && frame_boundary) begin
      staging_d = bcd;
      disp_d    = bcd;
      pending_d = 1'b0;
    end else if (upd) begin
      staging_d = bcd;
      pending_d = 1'b1;
    end else if (frame_boundary && pending_q) begin
      disp_d    = staging_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    cur_digit   = '0;
    bad_digit_d = 1'b0;
`ifdef BCD_SCAN_LZ_BLANK_EN
    upper_zero  = 1'b1;
`endif
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) cur_digit = disp_q[4*k +: 4];
      if (disp_q[4*k +: 4] > 4'd9) bad_digit_d = 1'b1;
`ifdef BCD_SCAN_LZ_BLANK_EN
      if (IW'(k) >= idx && disp_q[4*k +: 4] != 4'd0) upper_zero = 1'b0;
`endif
    end
    seg_d = seg_decode(cur_digit);
`ifdef BCD_SCAN_LZ_BLANK_EN
    if (idx != '0 && upper_zero) seg_d = 7'b0;
`endif
    dig_en_d = slot_start ? '0 : (DIGITS'(1) << idx);
  end

  always_ff @(posedge CK or negedge nClear) begin
    if (!nClear) begin
      staging_q    <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      seg_q        <= '0;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
      bad_digit_q  <= 1'b0;
    end else begin
      staging_q    <= staging_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_boundary;
      bad_digit_q  <= bad_digit_d;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;
  assign bad_digit  = bad_digit_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display (DIGITS=4, PRESCALE=4): cycle-level reference model plus pinned literal checks.
module tb_bcd_scan_display;

  localparam int D = 4;
  localparam int P = 4;
  localparam int F = D * P;

  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011, S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110, S7 = 7'b0000111, S9 = 7'b1101111, SD = 7'b1000000;
`ifdef BCD_SCAN_LZ_BLANK_EN
  localparam logic [6:0] LZ0 = 7'b0000000;
`else
  localparam logic [6:0] LZ0 = S0;
`endif

  logic        CK = 1'b0;
  logic        nClear = 1'b0;
  logic        upd = 1'b0;
  logic [15:0] bcd = 16'h0;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_done, bad_digit;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  bcd_scan_display #(.DIGITS(D), .PRESCALE(P), .PW(3)) dut (
    .CK(CK), .nClear(nClear), .bcd(bcd), .upd(upd),
    .seg(seg), .dig_en(dig_en), .frame_done(frame_done), .bad_digit(bad_digit)
  );

  always #5 CK = ~CK;

  function automatic logic [6:0] ref_seg(input int v);
    case (v)
      0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;
      3: return 7'b1001111;  4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;  8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  function automatic logic [6:0] digit_seg(input logic [15:0] v, input int slot);
    int d;
    d = int'((v >> (4 * slot)) & 16'hF);
`ifdef BCD_SCAN_LZ_BLANK_EN
    if (slot > 0 && (v >> (4 * slot)) == 16'h0) return 7'b0;
`endif
    return ref_seg(d);
  endfunction

  // Reference model: slot position follows from the number of clock edges since reset.
  int          cnt = 0;
  logic [15:0] m_disp = 16'h0, m_stage = 16'h0;
  bit          m_pend = 1'b0;
  logic [6:0]  e_seg = 7'h0;
  logic [3:0]  e_dig = 4'h0;
  bit          e_fd = 1'b0, e_bad = 1'b0;

  initial begin
    forever begin
      @(posedge CK or negedge nClear);
      if (!nClear) begin
        cnt = 0; m_disp = 16'h0; m_stage = 16'h0; m_pend = 1'b0;
        e_seg = 7'h0; e_dig = 4'h0; e_fd = 1'b0; e_bad = 1'b0;
      end else begin
        int pos, slot;
        bit bnd;
        pos  = cnt % P;
        slot = (cnt / P) % D;
        bnd  = (cnt % F) == F - 1;
        e_dig = (pos == 0) ? 4'h0 : 4'(1 << slot);
        e_seg = digit_seg(m_disp, slot);
        e_fd  = bnd;
        e_bad = 1'b0;
        for (int k = 0; k < D; k++)
          if (((m_disp >> (4 * k)) & 16'hF) > 16'd9) e_bad = 1'b1;
        if (upd && bnd) begin
          m_disp = bcd; m_stage = bcd; m_pend = 1'b0;
        end else if (upd) begin
          m_stage = bcd; m_pend = 1'b1;
        end else if (bnd && m_pend) begin
          m_disp = m_stage; m_pend = 1'b0;
        end
        cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CK);
      if (check_en) begin
        vectors++;
        if (seg !== e_seg || dig_en !== e_dig || frame_done !== e_fd || bad_digit !== e_bad) begin
          miscompares++;
          $display("FAIL model t=%0t seg %b want %b dig_en %b want %b frame_done %b want %b bad_digit %b want %b",
                   $time, seg, e_seg, dig_en, e_dig, frame_done, e_fd, bad_digit, e_bad);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic wait_fd(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CK);
      if (frame_done) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s: frame_done not seen within 40 cycles", tag);
    end
  endtask

  // Called at the frame_done sample; walks the next frame slot by slot and ends on its frame_done sample.
  task automatic scan_check(input string tag, input logic [27:0] segs);
    for (int k = 0; k < D; k++) begin
      @(negedge CK);
      chk({tag, "_dead"}, 32'(dig_en), 32'h0);
      @(negedge CK);
      chk({tag, "_dig_en"}, 32'(dig_en), 32'(1 << k));
      chk({tag, "_seg"}, 32'(seg), 32'(segs[7*k +: 7]));
      repeat (2) @(negedge CK);
    end
  endtask

  task automatic measure_release(input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CK);
      upd = 1'b0;
      if (frame_done) begin
        n = i;
        break;
      end
    end
    chk(tag, 32'(n), 32'd16);
  endtask

  task automatic pulse_upd(input logic [15:0] v);
    upd = 1'b1; bcd = v;
    @(negedge CK);
    upd = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge CK);
    nClear = 1'b1; upd = 1'b1; bcd = 16'h1234; check_en = 1'b1;
    measure_release("first_frame_done_latency");
    scan_check("scan_1234", {S1, S2, S3, S4});

    // Two updates inside one frame: only the last reaches the display.
    repeat (2) @(negedge CK);
    pulse_upd(16'h0005);
    repeat (3) @(negedge CK);
    pulse_upd(16'h0009);
    wait_fd("tear_free_boundary");
    scan_check("tear_free", {LZ0, LZ0, LZ0, S9});

    repeat (15) @(negedge CK);
    upd = 1'b1; bcd = 16'h7777;
    @(negedge CK);
    upd = 1'b0;
    chk("simul_boundary_frame_done", 32'(frame_done), 32'h1);
    scan_check("simul_7777", {S7, S7, S7, S7});
    scan_check("simul_7777_hold", {S7, S7, S7, S7});

    pulse_upd(16'h00A3);
    wait_fd("invalid_boundary");
    scan_check("invalid_00A3", {LZ0, LZ0, SD, S3});
    chk("bad_digit_set", 32'(bad_digit), 32'h1);
    pulse_upd(16'h0003);
    chk("bad_digit_before_boundary", 32'(bad_digit), 32'h1);
    wait_fd("invalid_fix_boundary");
    @(negedge CK);
    chk("bad_digit_clear", 32'(bad_digit), 32'h0);

    wait_fd("lz_align");
    pulse_upd(16'h0042);
    wait_fd("lz_42_boundary");
    scan_check("lz_0042", {LZ0, LZ0, S4, S2});
    pulse_upd(16'h0000);
    wait_fd("lz_0_boundary");
    scan_check("lz_0000", {LZ0, LZ0, LZ0, S0});

    // Asynchronous reset mid-slot with a bad digit shown and an update pending.
    pulse_upd(16'h00B1);
    wait_fd("reset_setup_boundary");
    repeat (2) @(negedge CK);
    chk("pre_reset_bad_digit", 32'(bad_digit), 32'h1);
    upd = 1'b1; bcd = 16'h5555;
    @(posedge CK);
    #2 nClear = 1'b0;
    upd = 1'b0;
    #1;
    chk("reset_seg", 32'(seg), 32'h0);
    chk("reset_dig_en", 32'(dig_en), 32'h0);
    chk("reset_bad_digit", 32'(bad_digit), 32'h0);
    chk("reset_frame_done", 32'(frame_done), 32'h0);
    repeat (2) @(negedge CK);
    nClear = 1'b1;
    measure_release("post_reset_frame_done_latency");
    scan_check("pending_lost", {LZ0, LZ0, LZ0, S0});

    for (int c = 0; c < 3000; c++) begin
      @(negedge CK);
      upd = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) bcd = 16'($urandom);
      else bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 999) == 0) begin
        #2 nClear = 1'b0;
        @(negedge CK);
        #2 nClear = 1'b1;
      end
    end
    @(negedge CK);
    upd = 1'b0;
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
